rvvi_retire_monitor: RTL and testbench

//  Consumer end of the RVVI trace for one hart: samples up to ISSUE retirements per clk,

---
 rtl/rvvi_retire_monitor_if.sv | 34 +++
 rtl/rvvi_retire_monitor.sv | 198 +++++++++++++++++++
 tb/tb_rvvi_retire_monitor.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvvi_retire_monitor_if.sv
// RVVI retirement trace (producer -> monitor) and the serialised retire stream
// (monitor -> reference-model comparator) for one hart.
interface rvvi_retire_monitor_if #(
    parameter int unsigned ILEN  = 32,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ISSUE = 2
);
    logic [ISSUE-1:0]      valid;
    logic [ISSUE*64-1:0]   order;
    logic [ISSUE*ILEN-1:0] insn;
    logic [ISSUE-1:0]      trap;
    logic [ISSUE-1:0]      halt;
    logic [ISSUE*2-1:0]    mode;
    logic [ISSUE*XLEN-1:0] pc_rdata;
    logic [ISSUE*XLEN-1:0] pc_wdata;

    logic                  out_valid;
    logic                  out_ready;
    logic [63:0]           out_order;
    logic [ILEN-1:0]       out_insn;
    logic [XLEN-1:0]       out_pc;
    logic                  out_trap;
    logic [1:0]            out_mode;

    modport master (
        output valid, order, insn, trap, halt, mode, pc_rdata, pc_wdata, out_ready,
        input  out_valid, out_order, out_insn, out_pc, out_trap, out_mode
    );

    modport slave (
        input  valid, order, insn, trap, halt, mode, pc_rdata, pc_wdata, out_ready,
        output out_valid, out_order, out_insn, out_pc, out_trap, out_mode
    );
endinterface

// File: rtl/rvvi_retire_monitor.sv
// RVVI consumer for one hart: checks order/PC sequencing of up to ISSUE retirements
// per cycle and serialises them in lane order through a first-word-fall-through FIFO.
module rvvi_retire_monitor #(
    parameter int unsigned ILEN  = 32,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ISSUE = 2,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    rvvi_retire_monitor_if.slave   rvvi,
    output logic [$clog2(DEPTH):0] level,
    output logic [63:0]            retire_count,
    output logic [31:0]            drop_count,
    output logic                   err_order,
    output logic                   err_pc,
    output logic                   err_lane,
    output logic                   err_overflow,
    output logic                   halted
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef struct packed {
        logic [63:0]     order;
        logic [ILEN-1:0] insn;
        logic [XLEN-1:0] pc;
        logic            trap;
        logic [1:0]      mode;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    entry_t          head_q, head_d;
    logic [63:0]     retire_count_q, retire_count_d;
    logic [31:0]     drop_count_q, drop_count_d;
    logic            err_order_q, err_order_d, err_pc_q, err_pc_d;
    logic            err_lane_q, err_lane_d, err_overflow_q, err_overflow_d;
    logic            halted_q, halted_d, first_seen_q, first_seen_d;
    logic [63:0]     exp_order_q, exp_order_d;
    logic [XLEN-1:0] prev_wdata_q, prev_wdata_d;
    logic            prev_trap_q, prev_trap_d;

    entry_t           stage [ISSUE];
    entry_t           lane_e;
    logic [XLEN-1:0]  lane_wdata;
    logic [ISSUE-1:0] acc, lower_valid;
    logic [LW-1:0]    n, push_n, free;
    logic             cut, halt_seen, drop, pop;
    logic             chk_first, chk_trap;
    logic [63:0]      chk_exp;
    logic [XLEN-1:0]  chk_wdata;

    // Bit k holds valid[k-1]; lane 0 has no lower neighbour so it never flags a hole.
    assign lower_valid = ISSUE'({rvvi.valid, 1'b1});

    always_comb begin
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        level_d        = level_q;
        head_d         = head_q;
        retire_count_d = retire_count_q;
        drop_count_d   = drop_count_q;
        err_order_d    = err_order_q;
        err_pc_d       = err_pc_q;
        err_lane_d     = err_lane_q;
        err_overflow_d = err_overflow_q;
        halted_d       = halted_q;

        acc       = '0;
        cut       = halted_q;
        halt_seen = 1'b0;
        for (int unsigned i = 0; i < ISSUE; i++) begin
            if (!cut && rvvi.valid[i]) begin
                acc[i] = 1'b1;
                if (rvvi.halt[i]) begin
                    cut       = 1'b1;
                    halt_seen = 1'b1;
                end
            end
        end
        if (|(acc & ~lower_valid)) err_lane_d = 1'b1;

        // Lanes are checked serially so each one's predecessor is the previous accepted lane.
        n          = '0;
        chk_first  = first_seen_q;
        chk_exp    = exp_order_q;
        chk_wdata  = prev_wdata_q;
        chk_trap   = prev_trap_q;
        lane_e     = '0;
        lane_wdata = '0;
        for (int unsigned j = 0; j < ISSUE; j++) stage[j] = '0;
        for (int unsigned i = 0; i < ISSUE; i++) begin
            lane_e.order = rvvi.order[i*64 +: 64];
            lane_e.insn  = rvvi.insn[i*ILEN +: ILEN];
            lane_e.pc    = rvvi.pc_rdata[i*XLEN +: XLEN];
            lane_e.trap  = rvvi.trap[i];
            lane_e.mode  = rvvi.mode[i*2 +: 2];
            lane_wdata   = rvvi.pc_wdata[i*XLEN +: XLEN];
            if (acc[i]) begin
                if (chk_first && lane_e.order != chk_exp) err_order_d = 1'b1;
                if (chk_first && !chk_trap && lane_e.pc != chk_wdata) err_pc_d = 1'b1;
                chk_first = 1'b1;
                chk_exp   = lane_e.order + 64'd1;
                chk_wdata = lane_wdata;
                chk_trap  = lane_e.trap;
                for (int unsigned j = 0; j < ISSUE; j++) begin
                    if (LW'(j) == n) stage[j] = lane_e;
                end
                n = n + LW'(1);
            end
        end
        first_seen_d   = chk_first;
        exp_order_d    = chk_exp;
        prev_wdata_d   = chk_wdata;
        prev_trap_d    = chk_trap;
        halted_d       = halted_q | halt_seen;
        retire_count_d = retire_count_q + 64'(n);

        free   = LW'(DEPTH) - level_q;
        drop   = n > free;
        pop    = (level_q != '0) && rvvi.out_ready;
        push_n = n;
        if (drop) begin
            push_n         = '0;
            err_overflow_d = 1'b1;
            if (drop_count_q != '1) drop_count_d = drop_count_q + 32'd1;
        end else begin
            for (int unsigned j = 0; j < ISSUE; j++) begin
                if (LW'(j) < n) mem_d[wr_ptr_q + AW'(j)] = stage[j];
            end
            wr_ptr_d = wr_ptr_q + AW'(n);
        end
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + push_n - LW'(pop);
        // Head register looks ahead through this cycle's push so data is ready with out_valid.
        if (level_d != '0) head_d = mem_d[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            head_q         <= '0;
            retire_count_q <= '0;
            drop_count_q   <= '0;
            err_order_q    <= 1'b0;
            err_pc_q       <= 1'b0;
            err_lane_q     <= 1'b0;
            err_overflow_q <= 1'b0;
            halted_q       <= 1'b0;
            first_seen_q   <= 1'b0;
            exp_order_q    <= '0;
            prev_wdata_q   <= '0;
            prev_trap_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            head_q         <= head_d;
            retire_count_q <= retire_count_d;
            drop_count_q   <= drop_count_d;
            err_order_q    <= err_order_d;
            err_pc_q       <= err_pc_d;
            err_lane_q     <= err_lane_d;
            err_overflow_q <= err_overflow_d;
            halted_q       <= halted_d;
            first_seen_q   <= first_seen_d;
            exp_order_q    <= exp_order_d;
            prev_wdata_q   <= prev_wdata_d;
            prev_trap_q    <= prev_trap_d;
        end
    end

    assign rvvi.out_valid = level_q != '0;
    assign rvvi.out_order = head_q.order;
    assign rvvi.out_insn  = head_q.insn;
    assign rvvi.out_pc    = head_q.pc;
    assign rvvi.out_trap  = head_q.trap;
    assign rvvi.out_mode  = head_q.mode;

    assign level        = level_q;
    assign retire_count = retire_count_q;
    assign drop_count   = drop_count_q;
    assign err_order    = err_order_q;
    assign err_pc       = err_pc_q;
    assign err_lane     = err_lane_q;
    assign err_overflow = err_overflow_q;
    assign halted       = halted_q;
endmodule

// File: tb/tb_rvvi_retire_monitor.sv
// Scoreboard bench for rvvi_retire_monitor: directed scenarios plus random traffic,
// checked against a lane-by-lane behavioural model and an expected-entry queue.
module tb_rvvi_retire_monitor;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned ISSUE = 2;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rvvi_retire_monitor_if #(.ILEN(ILEN), .XLEN(XLEN), .ISSUE(ISSUE)) rvvi ();

    logic [$clog2(DEPTH):0] level;
    logic [63:0]            retire_count;
    logic [31:0]            drop_count;
    logic                   err_order, err_pc, err_lane, err_overflow, halted;

    rvvi_retire_monitor #(.ILEN(ILEN), .XLEN(XLEN), .ISSUE(ISSUE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rvvi(rvvi), .level(level),
        .retire_count(retire_count), .drop_count(drop_count),
        .err_order(err_order), .err_pc(err_pc), .err_lane(err_lane),
        .err_overflow(err_overflow), .halted(halted)
    );

    typedef struct {
        bit          v;
        logic [63:0] order;
        logic [31:0] insn, pc, npc;
        bit          trap, halt;
        logic [1:0]  mode;
    } lane_t;

    typedef struct {
        logic [63:0] order;
        logic [31:0] insn, pc;
        logic        trap;
        logic [1:0]  mode;
    } exp_t;

    lane_t ln [ISSUE];
    exp_t  sb [$];
    exp_t  staged [$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    bit              m_first, m_pt, m_halted;
    longint unsigned m_exp, m_retire;
    logic [31:0]     m_pw;
    int unsigned     m_drop;
    bit              m_e_order, m_e_pc, m_e_lane, m_e_ovf;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        m_first = 0; m_pt = 0; m_halted = 0; m_exp = 0; m_retire = 0; m_pw = '0;
        m_drop = 0; m_e_order = 0; m_e_pc = 0; m_e_lane = 0; m_e_ovf = 0;
        sb.delete();
        staged.delete();
    endtask

    // One cycle of the trace as the consumer rules define it; accepted entries are staged
    // and enter the scoreboard once the clock edge that pushes them has happened.
    task automatic model_step();
        exp_t pend [$];
        bit   stop;
        stop = m_halted;
        for (int i = 0; i < ISSUE; i++) begin
            if (stop || !ln[i].v) continue;
            if (i > 0 && !ln[i-1].v) m_e_lane = 1;
            if (m_first) begin
                if (ln[i].order != m_exp) m_e_order = 1;
                if (!m_pt && ln[i].pc != m_pw) m_e_pc = 1;
            end
            m_first = 1;
            m_exp   = ln[i].order + 1;
            m_pw    = ln[i].npc;
            m_pt    = ln[i].trap;
            pend.push_back('{ln[i].order, ln[i].insn, ln[i].pc, ln[i].trap, ln[i].mode});
            if (ln[i].halt) stop = 1;
        end
        if (stop) m_halted = 1;
        m_retire += pend.size();
        if (pend.size() > DEPTH - sb.size()) begin
            m_e_ovf = 1;
            if (m_drop != 32'hFFFF_FFFF) m_drop++;
        end else begin
            foreach (pend[k]) staged.push_back(pend[k]);
        end
    endtask

    task automatic set_lane(int i, bit v, longint unsigned ord, logic [31:0] pc,
                            logic [31:0] npc, bit trap = 0, bit halt = 0);
        ln[i].v = v; ln[i].order = ord; ln[i].insn = $urandom; ln[i].pc = pc;
        ln[i].npc = npc; ln[i].trap = trap; ln[i].halt = halt;
        ln[i].mode = 2'($urandom_range(0, 3));
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < ISSUE; i++) set_lane(i, 0, 0, 0, 0);
    endtask

    task automatic drive(bit ready);
        for (int i = 0; i < ISSUE; i++) begin
            rvvi.valid[i]               = ln[i].v;
            rvvi.order[i*64 +: 64]      = ln[i].order;
            rvvi.insn[i*ILEN +: ILEN]   = ln[i].insn;
            rvvi.pc_rdata[i*XLEN +: XLEN] = ln[i].pc;
            rvvi.pc_wdata[i*XLEN +: XLEN] = ln[i].npc;
            rvvi.trap[i]                = ln[i].trap;
            rvvi.halt[i]                = ln[i].halt;
            rvvi.mode[i*2 +: 2]         = ln[i].mode;
        end
        rvvi.out_ready = ready;
        model_step();
        @(posedge clk);
        #1;
        while (staged.size() != 0) sb.push_back(staged.pop_front());
    endtask

    task automatic idle(int cycles, bit ready);
        clear_lanes();
        for (int c = 0; c < cycles; c++) drive(ready);
    endtask

    task automatic do_reset();
        clear_lanes();
        drive(0);
        reset = 1;
        rvvi.valid = '0;
        @(posedge clk);
        #1;
        reset = 0;
        model_clear();
    endtask

    task automatic check_status(string tag);
        chk({tag, ".retire_count"}, retire_count, m_retire);
        chk({tag, ".drop_count"}, 64'(drop_count), 64'(m_drop));
        chk({tag, ".err_order"}, 64'(err_order), 64'(m_e_order));
        chk({tag, ".err_pc"}, 64'(err_pc), 64'(m_e_pc));
        chk({tag, ".err_lane"}, 64'(err_lane), 64'(m_e_lane));
        chk({tag, ".err_overflow"}, 64'(err_overflow), 64'(m_e_ovf));
        chk({tag, ".halted"}, 64'(halted), 64'(m_halted));
    endtask

    // Monitor: DUT occupancy must track the scoreboard; every handshake pops and compares.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!mon_en || reset) continue;
            chk("mon.out_valid", 64'(rvvi.out_valid), 64'(sb.size() != 0));
            chk("mon.level", 64'(level), 64'(sb.size()));
            if (rvvi.out_valid && rvvi.out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("mon.out_order", rvvi.out_order, e.order);
                chk("mon.out_insn", 64'(rvvi.out_insn), 64'(e.insn));
                chk("mon.out_pc", 64'(rvvi.out_pc), 64'(e.pc));
                chk("mon.out_trap", 64'(rvvi.out_trap), 64'(e.trap));
                chk("mon.out_mode", 64'(rvvi.out_mode), 64'(e.mode));
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint unsigned g_ord;
        logic [31:0]     g_pc, npc;
        logic [3:0]      pat;
        int              rdy_pct;
        bit              tr;

        reset = 1;
        rvvi.out_ready = 0;
        clear_lanes();
        rvvi.valid = '0; rvvi.order = '0; rvvi.insn = '0; rvvi.trap = '0; rvvi.halt = '0;
        rvvi.mode = '0; rvvi.pc_rdata = '0; rvvi.pc_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        model_clear();
        mon_en = 1;
        chk("init.level", 64'(level), 0);
        chk("init.out_valid", 64'(rvvi.out_valid), 0);
        chk("init.out_order", rvvi.out_order, 0);
        check_status("init");

        // Two clean groups, contiguous orders and PC chain.
        set_lane(0, 1, 1, 32'h100, 32'h104); set_lane(1, 1, 2, 32'h104, 32'h108); drive(1);
        set_lane(0, 1, 3, 32'h108, 32'h10C); set_lane(1, 1, 4, 32'h10C, 32'h110); drive(1);
        idle(6, 1);
        check_status("basic");
        chk("basic.retire4", retire_count, 4);

        // Order gap 5 -> 7, then 8 follows the resynced expectation.
        do_reset();
        set_lane(1, 0, 0, 0, 0);
        set_lane(0, 1, 5, 32'h200, 32'h204); drive(1);
        set_lane(0, 1, 7, 32'h204, 32'h208); drive(1);
        set_lane(0, 1, 8, 32'h208, 32'h20C); drive(1);
        idle(4, 1);
        check_status("gap");
        chk("gap.err_order", 64'(err_order), 1);

        // Trapped predecessor suppresses the PC check; untrapped one does not.
        do_reset();
        set_lane(0, 1, 1, 32'h100, 32'h104, 1); set_lane(1, 1, 2, 32'h8000, 32'h8004); drive(1);
        idle(1, 1);
        check_status("trap");
        chk("trap.err_pc", 64'(err_pc), 0);
        set_lane(0, 1, 3, 32'h8004, 32'h104, 0); set_lane(1, 1, 4, 32'h8000, 32'h8004); drive(1);
        idle(3, 1);
        check_status("notrap");

        // Fill with consumer stalled; ninth group has no room.
        do_reset();
        for (int g = 0; g < 9; g++) begin
            set_lane(0, 1, 64'(2*g + 1), 32'(16*g), 32'(16*g + 4));
            set_lane(1, 1, 64'(2*g + 2), 32'(16*g + 4), 32'(16*g + 16));
            drive(0);
        end
        chk("ovf.level", 64'(level), 16);
        chk("ovf.drop_count", 64'(drop_count), 1);
        check_status("ovf");
        idle(20, 1);

        // Random traffic: holes, gaps, PC breaks, traps, variable back-pressure.
        do_reset();
        g_ord = 100; g_pc = 32'h1000; rdy_pct = 100;
        for (int c = 0; c < 800; c++) begin
            if (c % 50 == 0) begin
                case ($urandom_range(0, 2))
                    0: rdy_pct = 20;
                    1: rdy_pct = 60;
                    default: rdy_pct = 100;
                endcase
            end
            pat = 4'($urandom_range(0, (1 << ISSUE) - 1));
            for (int i = 0; i < ISSUE; i++) begin
                if (pat[i]) begin
                    if ($urandom_range(0, 19) == 0) g_ord += 2;
                    if ($urandom_range(0, 19) == 0) g_pc += 32'h40;
                    tr = ($urandom_range(0, 9) == 0);
                    npc = g_pc + 32'd4;
                    set_lane(i, 1, g_ord, g_pc, npc, tr, 0);
                    g_ord++;
                    g_pc = tr ? 32'($urandom) & 32'hFFFF_FFFC : npc;
                end else begin
                    set_lane(i, 0, 0, 0, 0);
                end
            end
            drive($urandom_range(0, 99) < rdy_pct);
            if (c % 100 == 99) check_status("rand");
        end
        idle(25, 1);
        check_status("rand_end");

        // Lane hole, then halt on lane 0 with lane 1 valid, then ignored traffic.
        do_reset();
        set_lane(0, 0, 0, 0, 0); set_lane(1, 1, 1, 32'h400, 32'h404); drive(1);
        chk("lane.err_lane", 64'(err_lane), 1);
        set_lane(0, 1, 2, 32'h404, 32'h408, 0, 1); set_lane(1, 1, 3, 32'h408, 32'h40C); drive(1);
        chk("halt.halted", 64'(halted), 1);
        for (int g = 0; g < 3; g++) begin
            set_lane(0, 1, 64'(10 + g), 32'h900, 32'h904); set_lane(1, 1, 64'(50 + g), 32'h0, 32'h4);
            drive(1);
        end
        idle(4, 1);
        chk("halt.retire2", retire_count, 2);
        check_status("halt");

        // Reset with entries queued and errors set.
        do_reset();
        set_lane(0, 1, 1, 32'h10, 32'h14); set_lane(1, 1, 3, 32'h14, 32'h18); drive(0);
        set_lane(0, 1, 4, 32'h18, 32'h1C); set_lane(1, 1, 5, 32'h1C, 32'h20); drive(0);
        set_lane(0, 1, 6, 32'h20, 32'h24); set_lane(1, 0, 0, 0, 0); drive(0);
        chk("rst.level5", 64'(level), 5);
        check_status("prerst");
        do_reset();
        chk("rst.level", 64'(level), 0);
        chk("rst.out_valid", 64'(rvvi.out_valid), 0);
        chk("rst.out_order", rvvi.out_order, 0);
        chk("rst.retire_count", retire_count, 0);
        chk("rst.drop_count", 64'(drop_count), 0);
        chk("rst.errors", 64'({err_order, err_pc, err_lane, err_overflow, halted}), 0);
        idle(3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
